reg_wb_unit: RTL and testbench

REG_WB_UNIT -- requirements
Module: reg_wb_unit

---
 rtl/reg_wb_unit_pkg.sv | 17 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/reg_wb_unit.sv | 140 ++++++++++++++
 tb/tb_reg_wb_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_unit_pkg.sv
// Shared widths and the write-back queue entry layout for the
// register write-back unit.
package reg_wb_unit_pkg;

  localparam int REG_IDX_W     = 2;
  localparam int DATA_W        = 8;
  localparam int NUM_REGS      = 4;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int ENTRY_W       = REG_IDX_W + DATA_W;
  localparam int CNT_W         = 2;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dst;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry queue for ALU results waiting on the register-file
// write port; wrapping 1-bit pointers plus an explicit count.
module wb_fifo
  import reg_wb_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset_,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [WB_FIFO_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(WB_FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/reg_wb_unit.sv
// Register-file write-back arbiter: load data beats queued ALU
// results, with a single-load scoreboard that stalls decode.
module reg_wb_unit
  import reg_wb_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_dst,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [REG_IDX_W-1:0] ld_dst,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_data,
  input  logic                 src_en_0,
  input  logic                 src_en_1,
  input  logic                 dst_en,
  input  logic [REG_IDX_W-1:0] src_sel_0,
  input  logic [REG_IDX_W-1:0] src_sel_1,
  input  logic [REG_IDX_W-1:0] dst_sel,
  output logic                 stall,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_sel,
  output logic [DATA_W-1:0]    wr_data,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 wb_err
);

  logic                 wr_en_q, wr_en_d;
  logic [REG_IDX_W-1:0] wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 wb_err_q, wb_err_d;
  logic                 ld_pending_q, ld_pending_d;
  logic [REG_IDX_W-1:0] ld_dst_q, ld_dst_d;

  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  wb_entry_t          head, alu_in;
  logic               alu_acc, ld_acc;
  logic               mem_win, fifo_win, byp_win;

  assign alu_in    = '{dst: alu_dst, data: alu_data};
  assign head      = wb_entry_t'(fifo_dout);
  assign alu_ready = ~fifo_full;
  assign alu_acc   = alu_valid & alu_ready;

  assign mem_win   = mem_rsp_valid & ld_pending_q;
  assign fifo_win  = ~mem_win & ~fifo_empty;
  assign byp_win   = ~mem_win & fifo_empty & alu_acc;
  assign fifo_pop  = fifo_win;
  assign fifo_push = alu_acc & ~byp_win;

  // busy is sampled pre-edge, so a same-cycle completion still stalls
  assign stall = (src_en_0 & busy_q[src_sel_0])
               | (src_en_1 & busy_q[src_sel_1])
               | (dst_en & busy_q[dst_sel])
               | (ld_issue & ld_pending_q & ~mem_rsp_valid);
  assign ld_acc = ld_issue & ~stall;

  wb_fifo u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (alu_in),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    wr_en_d   = mem_win | fifo_win | byp_win;
    wr_sel_d  = '0;
    wr_data_d = '0;
    unique case (1'b1)
      mem_win: begin
        wr_sel_d  = ld_dst_q;
        wr_data_d = mem_rsp_data;
      end
      fifo_win: begin
        wr_sel_d  = head.dst;
        wr_data_d = head.data;
      end
      byp_win: begin
        wr_sel_d  = alu_dst;
        wr_data_d = alu_data;
      end
      default: ;
    endcase
  end

  // set after clear: a back-to-back load to the same reg stays busy
  always_comb begin
    busy_d       = busy_q;
    ld_pending_d = ld_pending_q;
    ld_dst_d     = ld_dst_q;
    wb_err_d     = wb_err_q | (mem_rsp_valid & ~ld_pending_q);
    if (mem_win) begin
      busy_d[ld_dst_q] = 1'b0;
      ld_pending_d     = 1'b0;
    end
    if (ld_acc) begin
      busy_d[ld_dst] = 1'b1;
      ld_pending_d   = 1'b1;
      ld_dst_d       = ld_dst;
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
      wb_err_q     <= 1'b0;
      ld_pending_q <= 1'b0;
      ld_dst_q     <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      wb_err_q     <= wb_err_d;
      ld_pending_q <= ld_pending_d;
      ld_dst_q     <= ld_dst_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit: bypass, load priority, queue
// fill/backpressure, scoreboard stalls, stray responses, reset.
module tb_reg_wb_unit;

  logic       clk = 1'b0;
  logic       reset_;
  logic       alu_valid;
  logic [1:0] alu_dst;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       ld_issue;
  logic [1:0] ld_dst;
  logic       mem_rsp_valid;
  logic [7:0] mem_rsp_data;
  logic       src_en_0, src_en_1, dst_en;
  logic [1:0] src_sel_0, src_sel_1, dst_sel;
  logic       stall;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [3:0] busy;
  logic       wb_err;

  int total = 0;
  int bad   = 0;

  reg_wb_unit dut (
    .clk           (clk),
    .reset_        (reset_),
    .alu_valid     (alu_valid),
    .alu_dst       (alu_dst),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_dst        (ld_dst),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .src_en_0      (src_en_0),
    .src_en_1      (src_en_1),
    .dst_en        (dst_en),
    .src_sel_0     (src_sel_0),
    .src_sel_1     (src_sel_1),
    .dst_sel       (dst_sel),
    .stall         (stall),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_data       (wr_data),
    .busy          (busy),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_chk(input string tag, input logic en,
                        input logic [1:0] sel, input logic [7:0] d);
    chk({tag, ".en"}, 32'(wr_en), 32'(en));
    if (en) begin
      chk({tag, ".sel"}, 32'(wr_sel), 32'(sel));
      chk({tag, ".data"}, 32'(wr_data), 32'(d));
    end
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_fifo.count);
  endfunction

  initial begin
    reset_ = 1'b1;
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    ld_issue = 0; ld_dst = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    src_en_0 = 0; src_en_1 = 0; dst_en = 0;
    src_sel_0 = 0; src_sel_1 = 0; dst_sel = 0;
    #2;
    chk("rst.wr_en", 32'(wr_en), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.wb_err", 32'(wb_err), 0);
    chk("rst.alu_ready", 32'(alu_ready), 1);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.count", cnt(), 0);
    tick(); tick();
    reset_ = 1'b0;

    // ALU bypass with idle write port
    alu_valid = 1; alu_dst = 2; alu_data = 8'h5A;
    #1 chk("byp.ready", 32'(alu_ready), 1);
    tick();
    wr_chk("byp", 1, 2, 8'h5A);
    chk("byp.count", cnt(), 0);
    alu_valid = 0;
    tick();
    wr_chk("idle", 0, 0, 0);

    // load beats a simultaneous ALU result
    ld_issue = 1; ld_dst = 1;
    #1 chk("ld1.stall", 32'(stall), 0);
    tick();
    chk("ld1.busy", 32'(busy), 4'b0010);
    wr_chk("ld1.nowr", 0, 0, 0);
    ld_issue = 0;
    mem_rsp_valid = 1; mem_rsp_data = 8'h33;
    alu_valid = 1; alu_dst = 3; alu_data = 8'h11;
    tick();
    wr_chk("pri.mem", 1, 1, 8'h33);
    chk("pri.busy", 32'(busy), 0);
    chk("pri.count", cnt(), 1);
    mem_rsp_valid = 0; alu_valid = 0;
    tick();
    wr_chk("pri.alu", 1, 3, 8'h11);
    chk("pri.count2", cnt(), 0);
    tick();
    wr_chk("pri.idle", 0, 0, 0);

    // scoreboard stall on r2
    ld_issue = 1; ld_dst = 2;
    tick();
    ld_issue = 0;
    chk("sb.busy", 32'(busy), 4'b0100);
    src_en_0 = 1; src_sel_0 = 2;
    #1 chk("sb.stall_hit", 32'(stall), 1);
    src_sel_0 = 0;
    #1 chk("sb.stall_miss", 32'(stall), 0);
    src_sel_0 = 2;
    tick();
    chk("sb.stall_hold", 32'(stall), 1);
    mem_rsp_valid = 1; mem_rsp_data = 8'h77;
    #1 chk("sb.stall_samecyc", 32'(stall), 1);
    tick();
    mem_rsp_valid = 0;
    wr_chk("sb.wb", 1, 2, 8'h77);
    chk("sb.busy_clr", 32'(busy), 0);
    #1 chk("sb.stall_rel", 32'(stall), 0);
    src_en_0 = 0;

    // queue fill while loads keep winning the port
    ld_issue = 1; ld_dst = 0;
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 8'hC0;
    alu_valid = 1; alu_dst = 1; alu_data = 8'hA1;
    #1 chk("fill.ready0", 32'(alu_ready), 1);
    chk("fill.ldok", 32'(stall), 0);
    tick();
    wr_chk("fill.m1", 1, 0, 8'hC0);
    chk("fill.cnt1", cnt(), 1);
    chk("fill.busy", 32'(busy), 4'b0001);
    alu_dst = 2; alu_data = 8'hA2; mem_rsp_data = 8'hC1;
    tick();
    wr_chk("fill.m2", 1, 0, 8'hC1);
    chk("fill.cnt2", cnt(), 2);
    alu_dst = 3; alu_data = 8'hA3; mem_rsp_data = 8'hC2;
    #1 chk("fill.ready_lo", 32'(alu_ready), 0);
    tick();
    wr_chk("fill.m3", 1, 0, 8'hC2);
    chk("fill.cnt_hold", cnt(), 2);
    chk("fill.busy2", 32'(busy), 4'b0001);
    mem_rsp_valid = 0; ld_issue = 0;
    tick();
    wr_chk("fill.a1", 1, 1, 8'hA1);
    chk("fill.cnt3", cnt(), 1);
    #1 chk("fill.ready_hi", 32'(alu_ready), 1);
    tick();
    wr_chk("fill.a2", 1, 2, 8'hA2);
    chk("fill.cnt4", cnt(), 1);
    alu_valid = 0;
    tick();
    wr_chk("fill.a3", 1, 3, 8'hA3);
    chk("fill.cnt5", cnt(), 0);
    mem_rsp_valid = 1; mem_rsp_data = 8'h44;
    tick();
    mem_rsp_valid = 0;
    wr_chk("fill.ld", 1, 0, 8'h44);
    chk("fill.busy_clr", 32'(busy), 0);
    chk("fill.no_err", 32'(wb_err), 0);

    // stray response
    mem_rsp_valid = 1; mem_rsp_data = 8'h99;
    tick();
    mem_rsp_valid = 0;
    wr_chk("stray", 0, 0, 0);
    chk("stray.err", 32'(wb_err), 1);
    tick();
    chk("stray.sticky", 32'(wb_err), 1);

    // reset mid-fill
    ld_issue = 1; ld_dst = 3;
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 8'h55;
    alu_valid = 1; alu_dst = 1; alu_data = 8'h66;
    tick();
    chk("mr.pre_cnt", cnt(), 1);
    chk("mr.pre_busy", 32'(busy), 4'b1000);
    reset_ = 1'b1;
    #1;
    chk("mr.wr_en", 32'(wr_en), 0);
    chk("mr.wr_data", 32'(wr_data), 0);
    chk("mr.busy", 32'(busy), 0);
    chk("mr.err", 32'(wb_err), 0);
    chk("mr.cnt", cnt(), 0);
    chk("mr.ready", 32'(alu_ready), 1);
    chk("mr.stall", 32'(stall), 0);
    ld_issue = 0; mem_rsp_valid = 0; alu_valid = 0;
    tick();
    reset_ = 1'b0;
    mem_rsp_valid = 1; mem_rsp_data = 8'h12;
    tick();
    mem_rsp_valid = 0;
    wr_chk("mr.after", 0, 0, 0);
    chk("mr.after_err", 32'(wb_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
